// File: rtl/fetch_unit.sv
// Instruction fetch engine: ROM read, EXTENDED_ARG folding, one instruction per 3+2k cycles (k prefixes).
// Backpressure: a presented instruction is held in HOLD until OUT_READY; redirects override at any time.
module fetch_unit #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int ARG_WIDTH      = 24,
    parameter int EXT_ARG_OPCODE = 144,
    parameter int RESET_PC       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    START,
    input  logic                    REDIRECT_VALID,
    input  logic [ADDR_WIDTH-1:0]   REDIRECT_ADDR,
    output logic                    MEM_RD_EN,
    output logic [ADDR_WIDTH-1:0]   MEM_ADDR,
    input  logic [2*DATA_WIDTH-1:0] MEM_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [DATA_WIDTH-1:0]   OUT_OPCODE,
    output logic [ARG_WIDTH-1:0]    OUT_ARG,
    output logic [ADDR_WIDTH-1:0]   OUT_PC,
    output logic [ADDR_WIDTH-1:0]   OUT_NEXT_PC,
    output logic                    RUNNING
);

    localparam logic [DATA_WIDTH-1:0] EXT_OP = DATA_WIDTH'(EXT_ARG_OPCODE);
    localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   instr_pc;
    logic [ARG_WIDTH-1:0]    acc;
    logic                    prefix_pend;
    logic [DATA_WIDTH-1:0]   mem_opcode;
    logic [DATA_WIDTH-1:0]   mem_arg;
    logic [ARG_WIDTH-1:0]    folded_arg;
    logic                    is_prefix;
    logic                    handshake;

    assign mem_opcode = MEM_DATA[2*DATA_WIDTH-1:DATA_WIDTH];
    assign mem_arg    = MEM_DATA[DATA_WIDTH-1:0];
    assign folded_arg = (acc << DATA_WIDTH) | ARG_WIDTH'(mem_arg);
    assign is_prefix  = (mem_opcode == EXT_OP);
    assign handshake  = OUT_VALID & OUT_READY;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (REDIRECT_VALID) begin
            state_nxt = ISSUE;
        end else begin
            case (state)
                IDLE:    if (START) state_nxt = ISSUE;
                ISSUE:   state_nxt = CAPTURE;
                CAPTURE: state_nxt = is_prefix ? ISSUE : HOLD;
                HOLD:    if (handshake) state_nxt = ISSUE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        MEM_RD_EN = (state == ISSUE);
        MEM_ADDR  = (state == ISSUE) ? pc : '0;
        RUNNING   = (state != IDLE);
    end

    // prefix_pend rather than acc!=0 marks a pending prefix, so a zero-valued prefix keeps OUT_PC on the first word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RST_PC;
            acc         <= '0;
            prefix_pend <= 1'b0;
            instr_pc    <= '0;
            OUT_VALID   <= 1'b0;
            OUT_OPCODE  <= '0;
            OUT_ARG     <= '0;
            OUT_PC      <= '0;
            OUT_NEXT_PC <= '0;
        end else if (REDIRECT_VALID) begin
            pc          <= REDIRECT_ADDR;
            acc         <= '0;
            prefix_pend <= 1'b0;
            OUT_VALID   <= 1'b0;
        end else begin
            case (state)
                ISSUE: begin
                    if (!prefix_pend) instr_pc <= pc;
                    pc <= pc + ADDR_WIDTH'(1);
                end
                CAPTURE: begin
                    if (is_prefix) begin
                        acc         <= folded_arg;
                        prefix_pend <= 1'b1;
                    end else begin
                        OUT_OPCODE  <= mem_opcode;
                        OUT_ARG     <= folded_arg;
                        OUT_PC      <= instr_pc;
                        OUT_NEXT_PC <= pc;
                        OUT_VALID   <= 1'b1;
                        acc         <= '0;
                        prefix_pend <= 1'b0;
                    end
                end
                HOLD: begin
                    if (handshake) OUT_VALID <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered-read ROM model and table-driven redirect vectors.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        redirect_valid;
    logic [11:0] redirect_addr;
    logic        mem_rd_en;
    logic [11:0] mem_addr;
    logic [15:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_opcode;
    logic [23:0] out_arg;
    logic [11:0] out_pc;
    logic [11:0] out_next_pc;
    logic        running;

    logic [15:0] rom [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] addr;
        int          lat;
        logic [7:0]  op;
        logic [23:0] arg;
        logic [11:0] pc;
        logic [11:0] npc;
    } vec_t;

    vec_t vecs [5];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .START          (start),
        .REDIRECT_VALID (redirect_valid),
        .REDIRECT_ADDR  (redirect_addr),
        .MEM_RD_EN      (mem_rd_en),
        .MEM_ADDR       (mem_addr),
        .MEM_DATA       (mem_data),
        .OUT_VALID      (out_valid),
        .OUT_READY      (out_ready),
        .OUT_OPCODE     (out_opcode),
        .OUT_ARG        (out_arg),
        .OUT_PC         (out_pc),
        .OUT_NEXT_PC    (out_next_pc),
        .RUNNING        (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= rom[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // called at the negedge of the first cycle after the triggering edge
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_redirect(input logic [11:0] addr);
        redirect_valid = 1'b1;
        redirect_addr  = addr;
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic do_handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int   lat;
        logic seen_rd;
        logic stable;

        for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
        rom[12'h000] = 16'h6401;
        rom[12'h004] = 16'h9012; rom[12'h005] = 16'h9034; rom[12'h006] = 16'h7156;
        rom[12'h008] = 16'h90AB; rom[12'h009] = 16'h9012;
        rom[12'h00A] = 16'h9034; rom[12'h00B] = 16'h7156;
        rom[12'h020] = 16'h2233;
        rom[12'h030] = 16'h9000; rom[12'h031] = 16'h9005; rom[12'h032] = 16'h4207;
        rom[12'h040] = 16'h1190;
        rom[12'hFFF] = 16'h9001;

        vecs[0] = '{addr: 12'h004, lat: 7, op: 8'h71, arg: 24'h123456, pc: 12'h004, npc: 12'h007};
        vecs[1] = '{addr: 12'h008, lat: 9, op: 8'h71, arg: 24'h123456, pc: 12'h008, npc: 12'h00C};
        vecs[2] = '{addr: 12'h030, lat: 7, op: 8'h42, arg: 24'h000507, pc: 12'h030, npc: 12'h033};
        vecs[3] = '{addr: 12'h040, lat: 3, op: 8'h11, arg: 24'h000090, pc: 12'h040, npc: 12'h041};
        vecs[4] = '{addr: 12'hFFF, lat: 5, op: 8'h01, arg: 24'h000102, pc: 12'hFFF, npc: 12'h001};

        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; out_ready = 1'b0;
        seen_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen_rd |= mem_rd_en;
        end
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_outputs", {out_opcode, out_arg}, 0);
        chk("rst_pcs", {out_pc, out_next_pc}, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_no_read", 32'(seen_rd), 0);

        // plain fetch from the reset PC
        do_start();
        chk("plain_issue", {mem_rd_en, mem_addr}, {1'b1, 12'h000});
        wait_valid(lat);
        chk("plain_latency", lat, 3);
        chk("plain_opcode", 32'(out_opcode), 32'h64);
        chk("plain_arg", 32'(out_arg), 32'h000001);
        chk("plain_pc", 32'(out_pc), 0);
        chk("plain_next_pc", 32'(out_next_pc), 1);
        chk("plain_running", 32'(running), 1);
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!out_valid || out_opcode !== 8'h64 || out_arg !== 24'h000001 ||
                out_pc !== 12'h000 || out_next_pc !== 12'h001 || mem_rd_en) stable = 1'b0;
        end
        chk("plain_hold_stable", 32'(stable), 1);
        do_handshake();
        chk("plain_valid_drop", 32'(out_valid), 0);

        rom[12'h000] = 16'h0102;
        for (int v = 0; v < 5; v++) begin
            do_redirect(vecs[v].addr);
            chk($sformatf("v%0d_issue", v), {mem_rd_en, mem_addr}, {1'b1, vecs[v].addr});
            wait_valid(lat);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            chk($sformatf("v%0d_opcode", v), 32'(out_opcode), 32'(vecs[v].op));
            chk($sformatf("v%0d_arg", v), 32'(out_arg), 32'(vecs[v].arg));
            chk($sformatf("v%0d_pc", v), 32'(out_pc), 32'(vecs[v].pc));
            chk($sformatf("v%0d_next_pc", v), 32'(out_next_pc), 32'(vecs[v].npc));
            do_handshake();
            chk($sformatf("v%0d_valid_drop", v), 32'(out_valid), 0);
        end

        // redirect arriving while the prefix at 0x00A is in CAPTURE
        do_redirect(12'h00A);
        @(negedge clk);
        do_redirect(12'h020);
        wait_valid(lat);
        chk("capredir_latency", lat, 3);
        chk("capredir_opcode", 32'(out_opcode), 32'h22);
        chk("capredir_arg", 32'(out_arg), 32'h000033);
        chk("capredir_pc", 32'(out_pc), 32'h020);
        chk("capredir_next_pc", 32'(out_next_pc), 32'h021);

        // reset while an instruction is held
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_running", 32'(running), 0);
        chk("midrst_out_pc", 32'(out_pc), 0);
        do_start();
        chk("midrst_issue_pc", {mem_rd_en, mem_addr}, {1'b1, 12'h000});
        wait_valid(lat);
        chk("midrst_latency", lat, 3);
        chk("midrst_opcode", 32'(out_opcode), 32'h01);

        // handshake and redirect in the same cycle
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 12'h040;
        @(posedge clk);
        @(negedge clk);
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        chk("hsredir_valid_drop", 32'(out_valid), 0);
        chk("hsredir_issue", {mem_rd_en, mem_addr}, {1'b1, 12'h040});
        wait_valid(lat);
        chk("hsredir_latency", lat, 3);
        chk("hsredir_pc", 32'(out_pc), 32'h040);
        chk("hsredir_opcode", 32'(out_opcode), 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
